// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage: result-select
// encodings, default data width and the bubble instruction word.
package wb_regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREGS    = 32;
   localparam int AW       = 5;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } res_src_e;

   localparam logic [31:0] NOP_BUBBLE = 32'h0;

endpackage

// File: rtl/wb_regfile_core.sv
// 31-entry integer register file: one write port, two combinational read
// ports with hardwired x0 and same-cycle write-to-read bypass.
module wb_regfile_core
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_we,
   input  logic [AW-1:0]             i_waddr,
   input  logic [XLEN-1:0]           i_wdata,
   input  logic [1:0][AW-1:0]        i_raddr,
   output logic [1:0][XLEN-1:0]      o_rdata
);

   // x0 has no storage; entries start at 1
   logic [XLEN-1:0] r_regs [31:1];
   logic            w_wr_en;

   assign w_wr_en = i_we && (i_waddr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Bypass stays active during reset so decode sees the in-flight result
   for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
         o_rdata[p] = '0;
         if (i_raddr[p] == '0)                     o_rdata[p] = '0;
         else if (i_we && i_waddr == i_raddr[p])   o_rdata[p] = i_wdata;
         else                                      o_rdata[p] = r_regs[i_raddr[p]];
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, register file commit with decode read
// ports, and the retired-instruction counter.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  ReadData_wb,
   input  logic [XLEN-1:0]  ALUResult_wb,
   input  logic [XLEN-1:0]  PC_plus4_wb,
   input  logic [4:0]       rd_wb,
   input  logic             RegWrite_wb,
   input  logic [1:0]       ResultSrc_wb,
   input  logic [31:0]      instruction_wb,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   output logic [XLEN-1:0]  rd1_d,
   output logic [XLEN-1:0]  rd2_d,
   output logic [XLEN-1:0]  Result_wb,
   output logic [CNT_W-1:0] instret
);

   logic [XLEN-1:0]         w_result;
   logic [1:0][XLEN-1:0]    w_rdata;
   logic [CNT_W-1:0]        r_instret;

   always_comb begin
      w_result = ALUResult_wb;
      case (res_src_e'(ResultSrc_wb))
         RES_MEM: w_result = ReadData_wb;
         RES_PC4: w_result = PC_plus4_wb;
         default: w_result = ALUResult_wb;
      endcase
   end

   wb_regfile_core #(.XLEN(XLEN)) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_we    (RegWrite_wb),
      .i_waddr (rd_wb),
      .i_wdata (w_result),
      .i_raddr ({rs2_d, rs1_d}),
      .o_rdata (w_rdata)
   );

   // Stores and branches retire too, so only the bubble word is excluded
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          r_instret <= '0;
      else if (instruction_wb != NOP_BUBBLE) r_instret <= r_instret + 1'b1;
   end

   assign Result_wb = w_result;
   assign rd1_d     = w_rdata[0];
   assign rd2_d     = w_rdata[1];
   assign instret   = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver pushes expected outputs from an
// array-based model, a negedge monitor pops and compares.
module tb_wb_regfile;

   logic        clk = 0;
   logic        reset;
   logic [31:0] ReadData_wb, ALUResult_wb, PC_plus4_wb, instruction_wb;
   logic [4:0]  rd_wb, rs1_d, rs2_d;
   logic        RegWrite_wb;
   logic [1:0]  ResultSrc_wb;
   logic [31:0] rd1_d, rd2_d, Result_wb;
   logic [63:0] instret;
   logic [31:0] s_rd1, s_rd2, s_res;
   logic [3:0]  s_instret;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .reset(reset), .ReadData_wb(ReadData_wb), .ALUResult_wb(ALUResult_wb),
      .PC_plus4_wb(PC_plus4_wb), .rd_wb(rd_wb), .RegWrite_wb(RegWrite_wb),
      .ResultSrc_wb(ResultSrc_wb), .instruction_wb(instruction_wb), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .Result_wb(Result_wb), .instret(instret));

   // Narrow counter instance exercises the wrap boundary in a few cycles
   wb_regfile #(.XLEN(32), .CNT_W(4)) dut_w (
      .clk(clk), .reset(reset), .ReadData_wb(ReadData_wb), .ALUResult_wb(ALUResult_wb),
      .PC_plus4_wb(PC_plus4_wb), .rd_wb(rd_wb), .RegWrite_wb(RegWrite_wb),
      .ResultSrc_wb(ResultSrc_wb), .instruction_wb(instruction_wb), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .rd1_d(s_rd1), .rd2_d(s_rd2), .Result_wb(s_res), .instret(s_instret));

   typedef struct {
      logic [31:0] rd1, rd2, res;
      logic [63:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_regs [32];
   logic [63:0] m_cnt;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] m_result();
      case (ResultSrc_wb)
         2'd1:    return ReadData_wb;
         2'd2:    return PC_plus4_wb;
         default: return ALUResult_wb;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (RegWrite_wb && rd_wb == a) return m_result();
      return m_regs[a];
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("rd1_d", 64'(rd1_d), 64'(e.rd1));
         chk("rd2_d", 64'(rd2_d), 64'(e.rd2));
         chk("Result_wb", 64'(Result_wb), 64'(e.res));
         chk("instret", instret, e.cnt);
         chk("instret_wrap4", 64'(s_instret), 64'(e.cnt[3:0]));
      end
   end

   task automatic step(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [31:0] ins);
      exp_t e;
      @(posedge clk);
      // Commit what was presented during this edge
      if (!reset) begin
         if (RegWrite_wb && rd_wb != 0) m_regs[rd_wb] = m_result();
         if (instruction_wb != 0) m_cnt = m_cnt + 1;
      end
      #1;
      reset = rst; RegWrite_wb = we; rd_wb = rd; rs1_d = a1; rs2_d = a2;
      ResultSrc_wb = sel; ALUResult_wb = alu; ReadData_wb = mem; PC_plus4_wb = pc4;
      instruction_wb = ins;
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 0;
         m_cnt = 0;
      end
      e.rd1 = m_read(a1); e.rd2 = m_read(a2); e.res = m_result(); e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      step(0, 0, 0, a1, a2, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; RegWrite_wb = 0; rd_wb = 0; rs1_d = 0; rs2_d = 0; ResultSrc_wb = 0;
      ALUResult_wb = 0; ReadData_wb = 0; PC_plus4_wb = 0; instruction_wb = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_cnt = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

      // Bypass then storage
      step(0, 1, 5, 5, 0, 0, 32'hDEADBEEF, 0, 0, 32'h13);
      idle(5, 5);
      // x0 writes discarded
      step(0, 1, 0, 0, 0, 0, 32'h1234, 0, 0, 32'h13);
      idle(0, 0);
      // Result select into x7
      step(0, 1, 7, 7, 0, 1, 32'hC, 32'hA, 32'hB, 32'h13);
      idle(7, 7);
      step(0, 1, 7, 7, 7, 2, 32'hC, 32'hA, 32'hB, 32'h13);
      idle(7, 0);
      step(0, 1, 7, 0, 7, 3, 32'hC, 32'hA, 32'hB, 32'h13);
      idle(7, 7);

      // 10 slots with 3 bubbles from a clean counter
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 2 || i == 5 || i == 8) ? 32'h0 : 32'h33);
      idle(0, 0);
      idle(0, 0);
      // Narrow counter wraps across 20 retires
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h13);

      // Mid-stream asynchronous reset
      step(0, 1, 3, 0, 0, 0, 32'h55, 0, 0, 32'h13);
      idle(3, 0);
      step(1, 0, 0, 3, 3, 0, 0, 0, 0, 32'h13);
      step(1, 1, 4, 0, 0, 0, 32'h99, 0, 0, 32'h13);
      step(1, 0, 0, 4, 3, 0, 0, 0, 0, 32'h13);
      idle(4, 3);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         ins = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
         step(($urandom_range(0, 60) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
              $urandom, $urandom, $urandom, ins);
      end
      idle(0, 0);

      for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the five-stage RISC-V pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back result, commits it to the 32-entry integer register file, and serves the two decode-stage read ports with same-cycle write-to-read bypass. Also keeps a 64-bit retired-instruction counter for performance monitoring.

## Interface

Parameters:
- XLEN, 32, data width of registers, result and read ports
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ReadData_wb  input  XLEN  load data from the MEM/WB register
- ALUResult_wb  input  XLEN  ALU result from the MEM/WB register
- PC_plus4_wb  input  XLEN  link address from the MEM/WB register
- rd_wb  input  5  destination register index
- RegWrite_wb  input  1  write enable for rd_wb
- ResultSrc_wb  input  2  result select
- instruction_wb  input  32  instruction word in WB; all-zero encodes a bubble
- rs1_d  input  5  decode read address, port 1
- rs2_d  input  5  decode read address, port 2
- rd1_d  output  XLEN  read data, port 1
- rd2_d  output  XLEN  read data, port 2
- Result_wb  output  XLEN  selected write-back value (also routed to the forwarding mux)
- instret  output  CNT_W  count of retired non-bubble instructions

## Operation

- Result select: ResultSrc_wb 00 -> ALUResult_wb, 01 -> ReadData_wb, 10 -> PC_plus4_wb, 11 -> ALUResult_wb (reserved, defined for determinism). Combinational.
- Write: on rising clk, if RegWrite_wb = 1 and rd_wb != 0, regs[rd_wb] <= Result_wb. Writes to x0 are discarded; x0 has no storage.
- Read: combinational. For each port p with address rs: if rs = 0 -> 0; else if RegWrite_wb = 1 and rd_wb = rs -> Result_wb (bypass); else regs[rs].
- Both ports may address the same register and the write target simultaneously; both receive the bypassed value.
- Retire counter: on rising clk, if instruction_wb != 32'h0, instret <= instret + 1; wraps from 2^CNT_W-1 to 0. Independent of RegWrite_wb (stores and branches retire too).
- Reset: all registers x1..x31 and instret cleared to 0 asynchronously; while reset is high, rd1_d/rd2_d read 0 unless bypass applies (bypass remains combinational), no write or count occurs on clock edges.

## Timing

- Result_wb, rd1_d, rd2_d: zero-cycle combinational paths from inputs.
- Register write visible via bypass in the same cycle, via storage from the cycle after the edge.
- instret reflects a retiring instruction one cycle after it is present in WB.
- Reset deassertion: first write/count occurs on the first rising edge with reset low.
- Reset value of every output with all inputs zero: rd1_d = 0, rd2_d = 0, Result_wb = 0, instret = 0.

## Structure

- Shared pipeline package: ResultSrc encodings (RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10), XLEN, bubble encoding constant NOP_BUBBLE=32'h0.
- One sub-module: regfile_core (31x XLEN storage, one write port, two read ports with x0 and bypass logic). Result mux and retire counter live in wb_regfile top.

## Test plan

- Reset then read all 32 addresses -> every rd1_d/rd2_d = 0, instret = 0.
- Write ResultSrc=00, ALUResult_wb=32'hDEADBEEF, rd_wb=5, RegWrite=1, rs1_d=5 same cycle -> rd1_d = 32'hDEADBEEF (bypass); next cycle with RegWrite=0 -> rd1_d still 32'hDEADBEEF.
- Write rd_wb=0, RegWrite=1, ALUResult_wb=32'h1234 with rs1_d=rs2_d=0 -> both read 0 same cycle and after.
- Cycle ResultSrc 01/10/11 with ReadData=32'hA, PC_plus4=32'hB, ALU=32'hC into x7 -> x7 reads A, B, C in turn.
- Feed 10 instructions with 3 zero words interleaved -> instret = 7; preload counter near max (force 2^64-1) plus one retire -> instret = 0.
- Assert reset mid-stream after writing x3=32'h55 -> x3 reads 0 immediately (asynchronous), instret = 0, no write on edges during reset.
